// File: rtl/uart_tx_fifo_if.sv
// Byte push handshake from the CPU peripheral bus into uart_tx_fifo.
// The producer holds tx_data while tx_valid is high until tx_ready.
interface uart_tx_fifo_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a 4-entry byte FIFO, 8N1 frames, LSB first.
// Define UART_TX_PARITY_EN to add an even-parity bit (start, 8 data, parity, stop).
module uart_tx_fifo #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic          sysclk,
  input  logic          reset,
  uart_tx_fifo_if.slave bus,
  output logic          UART_TX,
  output logic          tx_busy,
  output logic [2:0]    fifo_count
);
  localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  logic [7:0]    mem [4];
  logic [1:0]    wr_ptr;
  logic [1:0]    rd_ptr;
  logic [7:0]    head;
  logic          push;
  logic          pop;
  logic          empty;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          tick;
  logic          line;
`ifdef UART_TX_PARITY_EN
  logic          par;
`endif

  assign empty       = (fifo_count == 3'd0);
  assign bus.tx_ready = (fifo_count != 3'd4) && reset;
  assign push        = bus.tx_valid && bus.tx_ready;
  assign tick        = (cnt == CNT_MAX);
  assign head        = mem[rd_ptr];
  // Pop only where a new frame can start: from idle, or at the last stop cycle.
  assign pop         = !empty &&
                       ((state == IDLE) || ((state == STOP) && tick));
  assign tx_busy     = (state != IDLE) || !empty;

  always_ff @(posedge sysclk) begin
    if (push) begin
      mem[wr_ptr] <= bus.tx_data;
    end
  end

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      fifo_count <= 3'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_comb begin
    line = 1'b1;
    unique case (state)
      START:   line = 1'b0;
      DATA:    line = shift[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  line = par;
`endif
      default: line = 1'b1;
    endcase
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      par <= 1'b0;
    end else if (pop) begin
      par <= ^head;
    end
  end
`endif

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'd0;
      UART_TX <= 1'b1;
    end else begin
      UART_TX <= line;
      cnt     <= ((state == IDLE) || tick) ? '0 : cnt + CW'(1);
      unique case (state)
        IDLE: begin
          if (pop) begin
            shift <= head;
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            bit_idx <= 3'd0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state <= STOP;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (pop) begin
              shift <= head;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table, burst, push/pop, reset.
// A line monitor decodes frames and compares them against a push-order queue.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
  localparam int CF      = 1000;
  localparam int BR      = 100;
  localparam int DIV     = 10;
  localparam int DEF_DIV = 10417;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * DIV;

  logic       sysclk = 1'b0;
  logic       reset  = 1'b0;
  logic       UART_TX;
  logic       tx_busy;
  logic [2:0] fifo_count;
  logic       line2;
  logic       busy2;
  logic [2:0] cnt2;

  uart_tx_fifo_if bus();
  uart_tx_fifo_if bus2();

  always #5 sysclk = ~sysclk;

  uart_tx_fifo #(.CLK_FREQ(CF), .BAUD(BR)) dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .bus        (bus),
    .UART_TX    (UART_TX),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count)
  );

  uart_tx_fifo dut_def (
    .sysclk     (sysclk),
    .reset      (reset),
    .bus        (bus2),
    .UART_TX    (line2),
    .tx_busy    (busy2),
    .fifo_count (cnt2)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  logic [7:0] q[$];
  bit mon_on = 1'b0;

  always @(posedge sysclk) begin
    if (mon_on && reset && bus.tx_valid && bus.tx_ready)
      q.push_back(bus.tx_data);
  end

  initial begin : monitor
    logic       prev;
    logic       s;
    logic       p;
    logic [7:0] b;
    logic [7:0] e;
    prev = 1'b1;
    p    = 1'b0;
    forever begin
      @(negedge sysclk);
      if (mon_on && prev === 1'b1 && UART_TX === 1'b0) begin
        repeat (DIV / 2) @(negedge sysclk);
        s = UART_TX;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge sysclk);
          b[i] = UART_TX;
        end
`ifdef UART_TX_PARITY_EN
        repeat (DIV) @(negedge sysclk);
        p = UART_TX;
`endif
        repeat (DIV) @(negedge sysclk);
        if (mon_on) begin
          chk("rx_start", int'(s), 0);
          chk("rx_stop", int'(UART_TX), 1);
          if (q.size() == 0) begin
            chk("rx_unexpected_frame", int'(b), -1);
          end else begin
            e = q.pop_front();
            chk("rx_byte", int'(b), int'(e));
`ifdef UART_TX_PARITY_EN
            chk("rx_parity", int'(p), int'(^e));
`endif
          end
        end
      end
      prev = UART_TX;
    end
  end

  typedef struct {
    logic [7:0]    data;
    logic [NB-1:0] line;
  } vec_t;

  vec_t vec[6];

  task automatic run_single(input vec_t v, input int idx);
    logic ls [FRAME + 20];
    logic bs [FRAME + 20];
    int   fall;
    int   nbusy;
    int   good;
    int   idle_hi;
    @(posedge sysclk); #1;
    bus.tx_valid = 1'b1;
    bus.tx_data  = v.data;
    @(posedge sysclk); #1;
    bus.tx_valid = 1'b0;
    for (int c = 0; c < FRAME + 20; c++) begin
      if (c > 0) begin
        @(posedge sysclk); #1;
      end
      ls[c] = UART_TX;
      bs[c] = tx_busy;
    end
    fall = -1;
    for (int c = FRAME + 19; c >= 0; c--)
      if (ls[c] === 1'b0) fall = c;
    chk($sformatf("v%0d_fall_latency", idx), fall, 2);
    nbusy = 0;
    for (int c = 0; c < FRAME + 20; c++)
      if (bs[c] === 1'b1) nbusy++;
    chk($sformatf("v%0d_busy_cycles", idx), nbusy, FRAME + 1);
    for (int j = 0; j < NB; j++) begin
      good = 0;
      for (int c = 2 + DIV * j; c < 2 + DIV * (j + 1); c++)
        if (ls[c] === v.line[j]) good++;
      chk($sformatf("v%0d_bit%0d_cycles", idx, j), good, DIV);
    end
    idle_hi = 0;
    for (int c = 0; c < FRAME + 20; c++)
      if ((c < 2 || c >= FRAME + 2) && ls[c] === 1'b1) idle_hi++;
    chk($sformatf("v%0d_idle_high", idx), idle_hi, 20);
  endtask

  task automatic run_burst();
    logic [7:0] d [5];
    int full_seen;
    int viol;
    int c0;
    int cb;
    int t;
    d = '{8'hFF, 8'h00, 8'hFA, 8'hC6, 8'h85};
    full_seen = 0;
    viol      = 0;
    c0        = -1;
    cb        = -1;
    t         = 0;
    @(posedge sysclk); #1;
    fork
      begin
        bus.tx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
          bus.tx_data = d[i];
          t = 0;
          do begin
            @(negedge sysclk);
            t++;
          end while (!bus.tx_ready && t < 2000);
          @(posedge sysclk); #1;
        end
        bus.tx_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 5 * FRAME + 100; c++) begin
          @(negedge sysclk);
          if (fifo_count == 3'd4) begin
            full_seen++;
            if (bus.tx_ready) viol++;
          end
          if (c0 < 0 && UART_TX === 1'b0) c0 = c;
          if (c0 >= 0 && cb < 0 && tx_busy === 1'b0) cb = c;
        end
      end
    join
    chk("burst_ready_wait", int'(t < 2000), 1);
    chk("burst_full_seen", int'(full_seen > 0), 1);
    chk("burst_ready_low_when_full", viol, 0);
    chk("burst_line_span", cb - c0 + 1, 5 * FRAME);
  endtask

  task automatic run_pushpop();
    @(posedge sysclk); #1;
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h3C;
    @(posedge sysclk); #1;
    bus.tx_data  = 8'hA5;
    @(posedge sysclk); #1;
    bus.tx_data  = 8'h0F;
    @(posedge sysclk); #1;
    bus.tx_valid = 1'b0;
    repeat (FRAME - 2) @(posedge sysclk);
    #1;
    chk("pp_count_before", int'(fifo_count), 2);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h96;
    @(posedge sysclk); #1;
    bus.tx_valid = 1'b0;
    chk("pp_count_after", int'(fifo_count), 2);
    chk("pp_stop_last", int'(UART_TX), 1);
    @(posedge sysclk); #1;
    chk("pp_next_start", int'(UART_TX), 0);
    repeat (4 * FRAME + 20) @(posedge sysclk);
    #1;
    chk("pp_idle_busy", int'(tx_busy), 0);
  endtask

  task automatic run_reset_mid();
    int lows;
    int busy;
    mon_on = 1'b0;
    @(posedge sysclk); #1;
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'hC6;
    @(posedge sysclk); #1;
    bus.tx_data  = 8'h85;
    @(posedge sysclk); #1;
    bus.tx_valid = 1'b0;
    repeat (35) @(posedge sysclk);
    #1;
    chk("rst_count_before", int'(fifo_count), 1);
    reset = 1'b0;
    #1;
    chk("rst_ready_low", int'(bus.tx_ready), 0);
    @(posedge sysclk); #1;
    chk("rst_line_high", int'(UART_TX), 1);
    chk("rst_count_flushed", int'(fifo_count), 0);
    chk("rst_busy_low", int'(tx_busy), 0);
    @(posedge sysclk); #1;
    reset = 1'b1;
    lows = 0;
    busy = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge sysclk);
      if (UART_TX !== 1'b1) lows++;
      if (tx_busy !== 1'b0) busy++;
    end
    chk("rst_line_quiet", lows, 0);
    chk("rst_busy_quiet", busy, 0);
    mon_on = 1'b1;
  endtask

  task automatic run_default_div();
    int   t;
    int   w;
    logic lvl;
    @(posedge sysclk); #1;
    bus2.tx_valid = 1'b1;
    bus2.tx_data  = 8'h55;
    @(posedge sysclk); #1;
    bus2.tx_valid = 1'b0;
    t = 0;
    while (line2 !== 1'b0 && t < 20) begin
      @(posedge sysclk); #1;
      t++;
    end
    chk("def_fall_latency", t, 2);
    chk("def_busy", int'(busy2), 1);
    chk("def_count_popped", int'(cnt2), 0);
    for (int k = 0; k < 3; k++) begin
      lvl = line2;
      w   = 0;
      while (line2 === lvl && w < 20000) begin
        @(posedge sysclk); #1;
        w++;
      end
      chk($sformatf("def_bit%0d_width", k), w, DEF_DIV);
    end
  endtask

  initial begin
`ifdef UART_TX_PARITY_EN
    vec[0] = '{8'h55, 11'b1_0_01010101_0};
    vec[1] = '{8'h00, 11'b1_0_00000000_0};
    vec[2] = '{8'hFF, 11'b1_0_11111111_0};
    vec[3] = '{8'hC6, 11'b1_0_11000110_0};
    vec[4] = '{8'h85, 11'b1_1_10000101_0};
    vec[5] = '{8'hFA, 11'b1_0_11111010_0};
`else
    vec[0] = '{8'h55, 10'b1_01010101_0};
    vec[1] = '{8'h00, 10'b1_00000000_0};
    vec[2] = '{8'hFF, 10'b1_11111111_0};
    vec[3] = '{8'hC6, 10'b1_11000110_0};
    vec[4] = '{8'h85, 10'b1_10000101_0};
    vec[5] = '{8'hFA, 10'b1_11111010_0};
`endif
    bus.tx_valid  = 1'b0;
    bus.tx_data   = 8'h00;
    bus2.tx_valid = 1'b0;
    bus2.tx_data  = 8'h00;
    reset = 1'b0;
    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    chk("reset_line", int'(UART_TX), 1);
    chk("reset_busy", int'(tx_busy), 0);
    chk("reset_count", int'(fifo_count), 0);
    chk("reset_ready", int'(bus.tx_ready), 0);
    @(posedge sysclk); #1;
    reset = 1'b1;
    @(negedge sysclk);
    chk("ready_after_reset", int'(bus.tx_ready), 1);
    mon_on = 1'b1;

    for (int v = 0; v < 6; v++)
      run_single(vec[v], v);
    run_burst();
    repeat (20) @(posedge sysclk);
    run_pushpop();
    run_reset_mid();
    run_default_div();
    chk("scoreboard_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
